// File: rtl/dff_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dff_reg_arbiter_if
//  Brief    : Requester/register bus shared by the arbiter and its clients.
//  Revision : 1.0
// ============================================================================
interface dff_reg_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [3:0]         lock;
    logic [4*WIDTH-1:0] data_in;
    logic [3:0]         gnt;
    logic [3:0]         ack;
    logic [WIDTH-1:0]   Q;
    logic [1:0]         owner;
    logic               busy;

    modport master (
        output req, lock, data_in,
        input  gnt, ack, Q, owner, busy
    );

    modport slave (
        input  req, lock, data_in,
        output gnt, ack, Q, owner, busy
    );
endinterface
`default_nettype wire

// File: rtl/dff_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dff_reg_arbiter
//  Brief    : Four-way round-robin arbiter owning a shared WIDTH-bit register,
//             with lockable tenures bounded to MAX_HOLD writes.
//  Revision : 1.0
// ============================================================================
module dff_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              sync_rst,
    dff_reg_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    localparam logic [3:0] C_MAX_HOLD = 4'(MAX_HOLD);

    state_t           r_state_q,    w_state_d;
    logic [3:0]       r_gnt_q,      w_gnt_d;
    logic [3:0]       r_ack_q,      w_ack_d;
    logic [WIDTH-1:0] r_q_q,        w_q_d;
    logic [1:0]       r_owner_q,    w_owner_d;
    logic [1:0]       r_ptr_q,      w_ptr_d;
    logic [3:0]       r_hold_cnt_q, w_hold_cnt_d;

    logic [1:0]       w_idx;
    logic [1:0]       w_win;
    logic             w_found;
    logic             w_continue;

    // Search starts at ptr, which sits one past the last winner, so a
    // releasing owner is considered last and only re-wins when alone.
    always_comb begin
        w_win   = r_ptr_q;
        w_found = 1'b0;
        w_idx   = r_ptr_q;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr_q + 2'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_continue = (r_state_q == ST_OWNED)
                     && bus.req[r_owner_q]
                     && bus.lock[r_owner_q]
                     && (r_hold_cnt_q < C_MAX_HOLD);

    always_comb begin
        w_state_d    = r_state_q;
        w_gnt_d      = r_gnt_q;
        w_ack_d      = '0;
        w_q_d        = r_q_q;
        w_owner_d    = r_owner_q;
        w_ptr_d      = r_ptr_q;
        w_hold_cnt_d = r_hold_cnt_q;

        if (w_continue) begin
            w_q_d        = bus.data_in[r_owner_q*WIDTH +: WIDTH];
            w_ack_d      = 4'b0001 << r_owner_q;
            w_hold_cnt_d = r_hold_cnt_q + 4'd1;
        end else if (w_found) begin
            // Covers both a fresh grant from IDLE and a back-to-back handover.
            w_state_d    = ST_OWNED;
            w_gnt_d      = 4'b0001 << w_win;
            w_ack_d      = 4'b0001 << w_win;
            w_q_d        = bus.data_in[w_win*WIDTH +: WIDTH];
            w_owner_d    = w_win;
            w_ptr_d      = w_win + 2'd1;
            w_hold_cnt_d = 4'd1;
        end else begin
            w_state_d = ST_IDLE;
            w_gnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state_q    <= ST_IDLE;
            r_gnt_q      <= '0;
            r_ack_q      <= '0;
            r_q_q        <= '0;
            r_owner_q    <= '0;
            r_ptr_q      <= '0;
            r_hold_cnt_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_gnt_q      <= w_gnt_d;
            r_ack_q      <= w_ack_d;
            r_q_q        <= w_q_d;
            r_owner_q    <= w_owner_d;
            r_ptr_q      <= w_ptr_d;
            r_hold_cnt_q <= w_hold_cnt_d;
        end
    end

    assign bus.gnt   = r_gnt_q;
    assign bus.ack   = r_ack_q;
    assign bus.Q     = r_q_q;
    assign bus.owner = r_owner_q;
    assign bus.busy  = (r_state_q == ST_OWNED);

endmodule
`default_nettype wire

// File: doc/dff_reg_arbiter.md
DFF_REG_ARBITER -- requirements
Module: dff_reg_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, width of the shared register and of each requester data slice.
REQ-002 Parameter: MAX_HOLD, default 4, maximum writes per tenure; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: sync_rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req  input  4  per-requester write request, bit i = requester i.
REQ-006 Port: lock  input  4  per-requester tenure-hold request, meaningful only for the current owner.
REQ-007 Port: data_in  input  4*WIDTH  requester data; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 Port: gnt  output  4  registered one-hot grant; all zero when no owner.
REQ-009 Port: ack  output  4  registered one-cycle pulse per accepted write, one-hot.
REQ-010 Port: Q  output  WIDTH  shared register contents.
REQ-011 Port: owner  output  2  index of the last granted requester.
REQ-012 Port: busy  output  1  high while state is OWNED.

Function
REQ-013 States: IDLE and OWNED; busy and gnt != 0 occur only in OWNED.
REQ-014 Arbitration: round-robin from pointer ptr (2 bits); search order ptr, ptr+1, ptr+2, ptr+3 mod 4; the first set req bit wins.
REQ-015 Grant edge: gnt <= 1<<w, ack <= 1<<w, Q <= data_in slice w, owner <= w, ptr <= w+1 mod 4, hold_cnt <= 1, state <= OWNED.
REQ-016 Latency: one edge from req sampled high to gnt, ack and Q update.
REQ-017 IDLE with req == 0: all registers hold; ack = 0.
REQ-018 IDLE with req != 0: perform a grant edge (REQ-015).
REQ-019 OWNED continue: when req[owner] && lock[owner] && hold_cnt < MAX_HOLD, write Q <= data_in[owner], pulse ack[owner], hold_cnt++, and keep gnt.
REQ-020 OWNED release: any other condition ends the tenure on that edge.
REQ-021 Release with req != 0: re-arbitrate on the same edge (REQ-015, back-to-back, no dead cycle); the owner can re-win only if its request is the sole one set.
REQ-022 Release with req == 0: gnt <= 0, ack <= 0, state <= IDLE; Q and owner hold.
REQ-023 Owner drops req mid-tenure: release on the next edge per REQ-020/021; that edge does not write the owner's data.
REQ-024 ack is high only on an edge where Q was written; at most one bit is set.
REQ-025 lock bits of non-owners are ignored; lock never affects arbitration order.

Reset
REQ-026 sync_rst sampled high on an edge has priority over all other inputs.
REQ-027 Reset values: state = IDLE, gnt = 0, ack = 0, Q = 0, owner = 0, busy = 0, ptr = 0, hold_cnt = 0.
REQ-028 Reset mid-tenure aborts the tenure with no write; the first arbitration after reset starts from requester 0.
REQ-029 While sync_rst is low and clk is not toggling, there are no output changes.

Verification (WIDTH=8, MAX_HOLD=4)
REQ-030 Reset: sync_rst=1, req=4'hF, data all 8'hFF for one edge -> Q=8'h00, gnt=0, ack=0, busy=0, owner=0.
REQ-031 Single write: req=4'b0001, lock=0, data0=8'hA5 for one edge, then req=0 -> edge 1: gnt=0001, ack=0001, Q=A5; edge 2: gnt=0, busy=0, Q stays A5.
REQ-032 Fairness: req=4'hF held, lock=0, data i = 8'h10+i -> consecutive edges grant 0,1,2,3,0; Q=10,11,12,13,10; ack one-hot each edge.
REQ-033 Hold limit: req=4'b0011, lock=4'b0001 held -> requester 0 gets 4 consecutive acks (hold_cnt 1..4); the 5th edge grants requester 1 with Q=data1.
REQ-034 Early drop: requester 0 owner with lock=1, req0 falls after 2 writes while req2=1 -> next edge gnt=0100, Q=data2, no third ack to requester 0.
REQ-035 Reset mid-tenure: sync_rst=1 during requester-2 hold -> gnt=0, Q=0; then req=4'b1010 -> requester 1 is granted first, then 3.
